net_frame_sequencer: RTL and testbench
======================================

# net_frame_sequencer

Frame-level controller between the engine's input AXI-Stream slave and the array of net cells. It accepts one fixed-length frame of window words and writes each word into the cells with an index. It then pulses a start, waits for every cell to report done, and hands the result to the output stage. Per-frame status and error flags go back to the AXI-Lite register file.

## Interface
Parameters:
- DATA_WIDTH, 32, stream/cell word width
- NET_CELL_COUNT, 2, number of net cells sharing the load bus
- FRAME_WORDS, 9 + (NET_CELL_COUNT-1)*3, words per frame (must be ≥ 2)
- TIMEOUT_CYCLES, 1024, WAIT_DONE watchdog limit (used only with the macro)

Ports:
- aclk  in  1  single clock for all logic
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  frame word
- s_axis_tvalid  in  1  word valid
- s_axis_tlast  in  1  last word of frame
- s_axis_tready  out  1  sequencer can accept
- cell_wr_en  out  1  load strobe to all cells
- cell_wr_idx  out  $clog2(FRAME_WORDS)  word position in frame
- cell_wr_data  out  DATA_WIDTH  word to cells
- cell_start  out  1  one-cycle compute start
- cell_done  in  NET_CELL_COUNT  per-cell done pulse or level
- out_req  out  1  result ready for the output stage
- out_ack  in  1  output stage has taken the result
- ctrl_enable  in  1  register-file run enable
- ctrl_clear  in  1  one-cycle clear of status and abort
- stat_state  out  3  current state encoding
- stat_frames  out  32  completed-frame count
- stat_err  out  1  sticky framing error
- stat_timeout  out  1  sticky watchdog expiry

## Operation
States: IDLE=0, LOAD=1, START=2, WAIT_DONE=3, DRAIN=4, FLUSH=5.

- **IDLE**
  - s_axis_tready=0.
  - Go to LOAD when ctrl_enable=1.
- **LOAD**
  - s_axis_tready=1.
  - Each accepted beat (tvalid&tready) is registered onto the cell_wr_* outputs, and the word counter increments.
  - Beat with tlast at counter == FRAME_WORDS-1: go to START.
  - Beat with tlast at counter < FRAME_WORDS-1 (short frame): set stat_err, reset the counter, stay in LOAD. The words already written are overwritten by the next frame.
  - Beat at counter == FRAME_WORDS-1 without tlast (long frame): set stat_err, go to FLUSH.
- **FLUSH**
  - s_axis_tready=1; beats are discarded and no cell_wr_en is issued.
  - Accepted tlast: go to LOAD with the counter at 0.
- **START**
  - cell_start=1 for exactly one cycle.
  - Clear the done-collect mask, then go to WAIT_DONE.
- **WAIT_DONE**
  - s_axis_tready=0.
  - The mask ORs in cell_done every cycle.
  - Mask all-ones: go to DRAIN. A done asserted in the START cycle is not captured.
- **DRAIN**
  - out_req=1, held until out_ack=1.
  - On out_ack: stat_frames increments (wraps at 2^32). Go to LOAD if ctrl_enable=1, else IDLE.
- **ctrl_enable deasserted mid-frame:** the current frame completes, then the block returns to IDLE.
- **ctrl_clear:**
  - Zeroes stat_frames, stat_err, stat_timeout and the counter, and forces IDLE.
  - It wins over every simultaneous event, including out_ack and a tlast beat in the same cycle.
- **stat_err / stat_timeout:** stay set until ctrl_clear or reset.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0, mask 0.
- **Load latency:** an accepted beat in cycle n appears as cell_wr_en/idx/data in cycle n+1.
- **tready:** a registered function of state only; it does not depend on tvalid.
- **Full frame:** from tlast acceptance, cell_start asserts 2 cycles later.
- **Earliest out_req:** the cycle after all done bits are collected.
- **out_ack without out_req:** ignored.
- **Reset mid-frame:** immediate return to IDLE; partial frame lost, no flags set.

## Configuration
- **NET_SEQ_TIMEOUT_EN defined:**
  - A watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: set stat_timeout and go to IDLE with no out_req and no frame count.
- **NET_SEQ_TIMEOUT_EN undefined:**
  - WAIT_DONE waits indefinitely.
  - stat_timeout is tied to 0 and TIMEOUT_CYCLES is unused.

## Structure
- **Shared package net_engine_pkg:**
  - state enum typedef with the encodings above;
  - FRAME_WORDS formula as a function of NET_CELL_COUNT;
  - stat_state width constant.
- **One sub-module, net_seq_watchdog:** load/count/expire counter, instantiated only under NET_SEQ_TIMEOUT_EN.

## Test plan
- **Nominal frame:** enable=1, NET_CELL_COUNT=2, 12 beats 0,0,1,2,3,6,7,8,9,12,13,14 with tlast on the 12th.
  - cell_wr_idx 0..11 carry that data.
  - cell_start pulses once; cell_done=2'b11 then gives out_req.
  - out_ack gives stat_frames=1.
- **Staggered done:** cell_done[0] at +3 cycles, cell_done[1] at +10 cycles → out_req rises exactly 1 cycle after the second done.
- **Short frame:** tlast on beat 5, then a full 12-beat frame.
  - stat_err=1 after beat 5.
  - The second frame completes normally and stat_frames=1.
- **Long frame:** 15 beats with tlast on the 15th.
  - stat_err=1; beats 13-15 get tready=1 with no cell_wr_en.
  - A following 12-beat frame completes.
- **Clear collision:** ctrl_clear in the same cycle as out_ack → stat_frames=0 and state IDLE.
- **Watchdog:** with NET_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, hold cell_done=0 → after 16 WAIT_DONE cycles, stat_timeout=1, state IDLE, no out_req.

Source files
------------

// File: rtl/net_engine_pkg.sv
// Shared definitions for the net engine: sequencer state encoding, the frame length formula
// and the width of the exported state field.
package net_engine_pkg;

  localparam int unsigned StatStateWidth = 3;

  typedef enum logic [StatStateWidth-1:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StStart    = 3'd2,
    StWaitDone = 3'd3,
    StDrain    = 3'd4,
    StFlush    = 3'd5
  } seq_state_e;

  // Window words per frame: 9 for the first cell, 3 more for each additional cell.
  function automatic int unsigned frame_words(input int unsigned cell_count);
    return 9 + (cell_count - 1) * 3;
  endfunction

endpackage

// File: rtl/net_seq_watchdog.sv
// Cycle watchdog: cleared by load_i, counts while count_i is high, and flags expiry on the
// Limit-th counted cycle.
module net_seq_watchdog #(
  parameter int unsigned Limit = 1024,
  localparam int unsigned CntWidth = $clog2(Limit + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Limit - 1);

  logic [CntWidth-1:0] cnt_q;

  // Count counted cycles; hold at the last value so the counter never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (count_i && (cnt_q != LastCnt)) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign expired_o = count_i && (cnt_q == LastCnt);

endmodule

// File: rtl/net_frame_sequencer.sv
// Frame-level controller: loads one fixed-length frame of words into the net cells, pulses
// start, collects every cell's done, then hands the result to the output stage.
// Optional build macro NET_SEQ_TIMEOUT_EN adds a watchdog on the done-collection phase.
module net_frame_sequencer
  import net_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NET_CELL_COUNT = 2,
  parameter int unsigned FRAME_WORDS    = frame_words(NET_CELL_COUNT),
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IdxWidth      = $clog2(FRAME_WORDS)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      cell_wr_en,
  output logic [IdxWidth-1:0]       cell_wr_idx,
  output logic [DATA_WIDTH-1:0]     cell_wr_data,
  output logic                      cell_start,
  input  logic [NET_CELL_COUNT-1:0] cell_done,
  output logic                      out_req,
  input  logic                      out_ack,
  input  logic                      ctrl_enable,
  input  logic                      ctrl_clear,
  output logic [StatStateWidth-1:0] stat_state,
  output logic [31:0]               stat_frames,
  output logic                      stat_err,
  output logic                      stat_timeout
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(FRAME_WORDS - 1);

  seq_state_e                state_q, state_d;
  logic [IdxWidth-1:0]       cnt_q, cnt_d;
  logic [NET_CELL_COUNT-1:0] mask_q, mask_d;
  logic [31:0]               frames_q, frames_d;
  logic                      err_q, err_d;
  logic                      wr_en_q, wr_en_d;
  logic [IdxWidth-1:0]       wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      tready_q;
  logic                      start_q;
  logic                      out_req_q;
  logic                      beat;
  logic                      done_all;
  logic                      wd_expired;

  assign beat     = s_axis_tvalid & tready_q;
  // Done seen this cycle counts, so out_req can follow the last done by one cycle.
  assign done_all = &(mask_q | cell_done);

`ifdef NET_SEQ_TIMEOUT_EN
  logic timeout_q;

  net_seq_watchdog #(
    .Limit (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .load_i    (state_q == StStart),
    .count_i   (state_q == StWaitDone),
    .expired_o (wd_expired)
  );

  // Sticky watchdog flag; a done arriving on the expiry cycle takes precedence.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timeout_q <= 1'b0;
    end else if (ctrl_clear) begin
      timeout_q <= 1'b0;
    end else if ((state_q == StWaitDone) && wd_expired && !done_all) begin
      timeout_q <= 1'b1;
    end
  end

  assign stat_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign wd_expired         = 1'b0;
  assign stat_timeout       = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state, frame counter, done mask, statistics and cell write bus.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    frames_d  = frames_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_enable) state_d = StLoad;
      end
      StLoad: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = cnt_q;
          wr_data_d = s_axis_tdata;
          if (cnt_q == LastIdx) begin
            cnt_d = '0;
            if (s_axis_tlast) begin
              state_d = StStart;
            end else begin
              // Long frame: drop the tail up to its tlast.
              err_d   = 1'b1;
              state_d = StFlush;
            end
          end else if (s_axis_tlast) begin
            // Short frame: restart; the next frame overwrites the partial load.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + IdxWidth'(1);
          end
        end else if (!ctrl_enable && (cnt_q == '0)) begin
          // Disabled between frames: no frame in progress to finish.
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (beat && s_axis_tlast) begin
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StStart: begin
        mask_d  = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        mask_d = mask_q | cell_done;
        if (done_all) begin
          state_d = StDrain;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (out_ack) begin
          frames_d = frames_q + 32'd1;
          state_d  = ctrl_enable ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear overrides every other event in the same cycle.
    if (ctrl_clear) begin
      state_d  = StIdle;
      cnt_d    = '0;
      frames_d = '0;
      err_d    = 1'b0;
      wr_en_d  = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mask_q    <= '0;
      frames_q  <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      tready_q  <= 1'b0;
      start_q   <= 1'b0;
      out_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      frames_q  <= frames_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      tready_q  <= (state_d == StLoad) || (state_d == StFlush);
      start_q   <= (state_q == StStart) && !ctrl_clear;
      out_req_q <= (state_d == StDrain);
    end
  end

  assign s_axis_tready = tready_q;
  assign cell_wr_en    = wr_en_q;
  assign cell_wr_idx   = wr_idx_q;
  assign cell_wr_data  = wr_data_q;
  assign cell_start    = start_q;
  assign out_req       = out_req_q;
  assign stat_state    = state_q;
  assign stat_frames   = frames_q;
  assign stat_err      = err_q;

endmodule

// File: tb/tb_net_frame_sequencer.sv
// Directed self-checking bench for net_frame_sequencer (2 cells, 12-word frames).
module tb_net_frame_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 2;
  localparam int unsigned IW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          cell_wr_en;
  logic [IW-1:0] cell_wr_idx;
  logic [DW-1:0] cell_wr_data;
  logic          cell_start;
  logic [NC-1:0] cell_done = '0;
  logic          out_req;
  logic          out_ack = 1'b0;
  logic          ctrl_enable = 1'b0;
  logic          ctrl_clear = 1'b0;
  logic [2:0]    stat_state;
  logic [31:0]   stat_frames;
  logic          stat_err;
  logic          stat_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  net_frame_sequencer #(
    .DATA_WIDTH     (DW),
    .NET_CELL_COUNT (NC),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .cell_wr_en    (cell_wr_en),
    .cell_wr_idx   (cell_wr_idx),
    .cell_wr_data  (cell_wr_data),
    .cell_start    (cell_start),
    .cell_done     (cell_done),
    .out_req       (out_req),
    .out_ack       (out_ack),
    .ctrl_enable   (ctrl_enable),
    .ctrl_clear    (ctrl_clear),
    .stat_state    (stat_state),
    .stat_frames   (stat_frames),
    .stat_err      (stat_err),
    .stat_timeout  (stat_timeout)
  );

  always #5 aclk = ~aclk;

  // Outputs are read, and inputs changed, 1 time unit after each rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Stimulus only: n beats with data 100+i, tlast on beat index last_at.
  task automatic send_beats(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(100 + i);
      s_axis_tlast  = (i == last_at);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Stimulus only: from START, collect both dones and acknowledge the result.
  task automatic finish_frame();
    tick();
    cell_done = 2'b11;
    tick();
    cell_done = 2'b00;
    out_ack   = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({s_axis_tready, cell_wr_en, cell_start, out_req, stat_err, stat_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {s_axis_tready, cell_wr_en, cell_start, out_req, stat_err, stat_timeout});
    end
    n_checks++;
    if (stat_state !== 3'd0 || stat_frames !== 32'd0 || cell_wr_idx !== 4'd0
        || cell_wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: state %0d frames %0d idx %0d data %0h expected all 0",
               stat_state, stat_frames, cell_wr_idx, cell_wr_data);
    end
    tick();
    aresetn = 1'b1;
    tick();
    n_checks++;
    if (stat_state !== 3'd0 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: state %0d tready %b expected 0 0", stat_state, s_axis_tready);
    end
    ctrl_enable = 1'b1;
    tick();
    n_checks++;
    if (stat_state !== 3'd1 || s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_load: state %0d tready %b expected 1 1", stat_state, s_axis_tready);
    end
  endtask

  task automatic test_nominal();
    logic [DW-1:0] d [12];
    d = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd6, 32'd7, 32'd8, 32'd9, 32'd12, 32'd13, 32'd14};
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tlast  = (i == 11);
      tick();
      n_checks++;
      if (cell_wr_en !== 1'b1 || cell_wr_idx !== IW'(i) || cell_wr_data !== d[i]) begin
        n_fail++;
        $display("FAIL nominal_write[%0d]: en %b idx %0d data %0d expected 1 %0d %0d",
                 i, cell_wr_en, cell_wr_idx, cell_wr_data, i, d[i]);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++;
    if (stat_state !== 3'd2 || cell_start !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_start_state: state %0d start %b tready %b expected 2 0 0",
               stat_state, cell_start, s_axis_tready);
    end
    tick();
    n_checks++;
    if (cell_start !== 1'b1 || stat_state !== 3'd3 || cell_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_start_pulse: start %b state %0d wr_en %b expected 1 3 0",
               cell_start, stat_state, cell_wr_en);
    end
    tick();
    n_checks++;
    if (cell_start !== 1'b0 || out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_start_once: start %b out_req %b expected 0 0", cell_start, out_req);
    end
    cell_done = 2'b11;
    tick();
    cell_done = 2'b00;
    n_checks++;
    if (out_req !== 1'b1 || stat_state !== 3'd4) begin
      n_fail++;
      $display("FAIL nominal_out_req: out_req %b state %0d expected 1 4", out_req, stat_state);
    end
    tick();
    n_checks++;
    if (out_req !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_out_req_hold: got %b expected 1", out_req);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    n_checks++;
    if (stat_frames !== 32'd1 || out_req !== 1'b0 || stat_state !== 3'd1) begin
      n_fail++;
      $display("FAIL nominal_ack: frames %0d out_req %b state %0d expected 1 0 1",
               stat_frames, out_req, stat_state);
    end
  endtask

  task automatic test_staggered();
    send_beats(12, 11);
    tick();
    n_checks++;
    if (cell_start !== 1'b1) begin
      n_fail++;
      $display("FAIL stagger_start: got %b expected 1", cell_start);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_checks++;
      if (out_req !== (k == 11)) begin
        n_fail++;
        $display("FAIL stagger_out_req[+%0d]: got %b expected %b", k, out_req, (k == 11));
      end
      cell_done = (k == 3) ? 2'b01 : ((k == 10) ? 2'b10 : 2'b00);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    n_checks++;
    if (stat_frames !== 32'd2) begin
      n_fail++;
      $display("FAIL stagger_frames: got %0d expected 2", stat_frames);
    end
  endtask

  task automatic test_ack_ignored();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    n_checks++;
    if (stat_frames !== 32'd2 || stat_state !== 3'd1) begin
      n_fail++;
      $display("FAIL stray_ack: frames %0d state %0d expected 2 1", stat_frames, stat_state);
    end
  endtask

  task automatic test_clear();
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    n_checks++;
    if (stat_state !== 3'd0 || stat_frames !== 32'd0 || stat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: state %0d frames %0d err %b expected 0 0 0",
               stat_state, stat_frames, stat_err);
    end
    tick();
  endtask

  task automatic test_short_frame();
    test_clear();
    send_beats(5, 4);
    n_checks++;
    if (stat_err !== 1'b1 || stat_state !== 3'd1 || cell_wr_idx !== 4'd4) begin
      n_fail++;
      $display("FAIL short_err: err %b state %0d idx %0d expected 1 1 4",
               stat_err, stat_state, cell_wr_idx);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hABCD;
    tick();
    n_checks++;
    if (cell_wr_idx !== 4'd0 || cell_wr_data !== 32'hABCD) begin
      n_fail++;
      $display("FAIL short_restart: idx %0d data %0h expected 0 abcd", cell_wr_idx, cell_wr_data);
    end
    send_beats(11, 10);
    n_checks++;
    if (stat_state !== 3'd2) begin
      n_fail++;
      $display("FAIL short_second_frame: state %0d expected 2", stat_state);
    end
    finish_frame();
    n_checks++;
    if (stat_frames !== 32'd1 || stat_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_done: frames %0d err %b expected 1 1", stat_frames, stat_err);
    end
  endtask

  task automatic test_long_frame();
    test_clear();
    send_beats(12, 99);
    n_checks++;
    if (stat_err !== 1'b1 || stat_state !== 3'd5 || cell_wr_en !== 1'b1 || cell_wr_idx !== 4'd11)
    begin
      n_fail++;
      $display("FAIL long_flush: err %b state %0d en %b idx %0d expected 1 5 1 11",
               stat_err, stat_state, cell_wr_en, cell_wr_idx);
    end
    for (int i = 12; i < 15; i++) begin
      n_checks++;
      if (s_axis_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL long_tready[%0d]: got %b expected 1", i, s_axis_tready);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 14);
      tick();
      n_checks++;
      if (cell_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL long_no_write[%0d]: got %b expected 0", i, cell_wr_en);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++;
    if (stat_state !== 3'd1) begin
      n_fail++;
      $display("FAIL long_back_to_load: state %0d expected 1", stat_state);
    end
    send_beats(12, 11);
    finish_frame();
    n_checks++;
    if (stat_frames !== 32'd1 || stat_state !== 3'd1) begin
      n_fail++;
      $display("FAIL long_next_frame: frames %0d state %0d expected 1 1", stat_frames, stat_state);
    end
  endtask

  task automatic test_clear_collision();
    send_beats(12, 11);
    tick();
    cell_done = 2'b11;
    tick();
    cell_done  = 2'b00;
    out_ack    = 1'b1;
    ctrl_clear = 1'b1;
    tick();
    out_ack    = 1'b0;
    ctrl_clear = 1'b0;
    n_checks++;
    if (stat_frames !== 32'd0 || stat_state !== 3'd0 || out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_collision: frames %0d state %0d out_req %b expected 0 0 0",
               stat_frames, stat_state, out_req);
    end
    tick();
  endtask

  task automatic test_enable_off();
    send_beats(6, 99);
    ctrl_enable = 1'b0;
    for (int i = 6; i < 12; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == 11);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    finish_frame();
    n_checks++;
    if (stat_state !== 3'd0 || stat_frames !== 32'd1) begin
      n_fail++;
      $display("FAIL enable_off: state %0d frames %0d expected 0 1", stat_state, stat_frames);
    end
    tick();
    n_checks++;
    if (stat_state !== 3'd0 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_off_hold: state %0d tready %b expected 0 0", stat_state, s_axis_tready);
    end
    ctrl_enable = 1'b1;
    tick();
  endtask

  task automatic test_watchdog();
    send_beats(12, 11);
`ifdef NET_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) begin
        n_checks++;
        if (stat_state !== 3'd3 || stat_timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL wd_last_wait: state %0d timeout %b expected 3 0", stat_state, stat_timeout);
        end
      end
    end
    tick();
    n_checks++;
    if (stat_timeout !== 1'b1 || stat_state !== 3'd0 || out_req !== 1'b0 || stat_frames !== 32'd1)
    begin
      n_fail++;
      $display("FAIL wd_expire: timeout %b state %0d out_req %b frames %0d expected 1 0 0 1",
               stat_timeout, stat_state, out_req, stat_frames);
    end
    tick();
`else
    for (int k = 0; k < 40; k++) tick();
    n_checks++;
    if (stat_timeout !== 1'b0 || stat_state !== 3'd3 || out_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_disabled: timeout %b state %0d out_req %b expected 0 3 0",
               stat_timeout, stat_state, out_req);
    end
    test_clear();
`endif
  endtask

  task automatic test_reset_mid_frame();
    n_checks++;
    if (stat_state !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got %0d expected 1", stat_state);
    end
    send_beats(4, 99);
    #1;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (stat_state !== 3'd0 || s_axis_tready !== 1'b0 || cell_wr_en !== 1'b0 || stat_err !== 1'b0
        || stat_timeout !== 1'b0 || stat_frames !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: state %0d tready %b en %b err %b to %b frames %0d expected 0",
               stat_state, s_axis_tready, cell_wr_en, stat_err, stat_timeout, stat_frames);
    end
    tick();
    aresetn = 1'b1;
    tick();
    send_beats(12, 11);
    n_checks++;
    if (stat_state !== 3'd2 || stat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fresh_frame: state %0d err %b expected 2 0", stat_state, stat_err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_staggered();
    test_ack_ignored();
    test_short_frame();
    test_long_frame();
    test_clear_collision();
    test_enable_off();
    test_watchdog();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish within 200000 time units");
    $fatal(1, "time limit");
  end

endmodule
